// File: rtl/mpu_pkg.sv
// Shared definitions for the mpu execution core.
// Contents: R-type opcode and funct constants, the ALU operation enum,
// and the packed structs that make up the ID, EX and WB pipeline registers.
package mpu_pkg;

    localparam logic [6:0] OPC_OP   = 7'b0110011;

    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    localparam logic [2:0] F3_ADD   = 3'b000;   // ADD / SUB
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SLT   = 3'b010;
    localparam logic [2:0] F3_SLTU  = 3'b011;
    localparam logic [2:0] F3_XOR   = 3'b100;
    localparam logic [2:0] F3_SR    = 3'b101;   // SRL / SRA
    localparam logic [2:0] F3_OR    = 3'b110;
    localparam logic [2:0] F3_AND   = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
    } id_stage_t;

    // we = valid, legal and rd != 0; it is the single qualifier used both
    // for forwarding and for the register-file write.
    typedef struct packed {
        logic        valid;
        logic        legal;
        logic        we;
        logic [4:0]  rd;
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
    } ex_stage_t;

    typedef struct packed {
        logic        valid;
        logic        legal;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_stage_t;

endpackage

// File: rtl/mpu_regfile.sv
// 32 x 32-bit register file for the mpu core.
// Ports:
//   clock, reset       - system clock, asynchronous active-high reset
//   raddr1/raddr2      - combinational read addresses
//   rdata1/rdata2      - read data (x0 always reads as zero)
//   we, waddr, wdata   - single synchronous write port (writes to x0 ignored)
// Reset loads x1 = R1_INIT, x2 = R2_INIT and zero everywhere else.
module mpu_regfile #(
    parameter logic [31:0] R1_INIT = 32'd0,
    parameter logic [31:0] R2_INIT = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            regs[1] <= R1_INIT;
            regs[2] <= R2_INIT;
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/mpu.sv
// mpu: three-stage (ID, EX, WB) RV32I R-type execution core.
// The instruction word is sampled every rising edge straight into ID;
// operands are read in ID with forwarding from EX and WB, the ALU runs in
// EX, and the result sits in WB for one cycle before the register file
// is written.
// Ports:
//   clock    - system clock
//   reset    - asynchronous active-high reset
//   instr    - instruction word, sampled every rising edge
//   wb_valid - WB holds a result that will be written
//   wb_rd    - WB destination register
//   wb_data  - WB result value
//   illegal  - WB holds an unsupported instruction
module mpu
    import mpu_pkg::*;
#(
    parameter logic [31:0] R1_INIT = 32'd0,
    parameter logic [31:0] R2_INIT = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal
);

    id_stage_t id_q;
    ex_stage_t ex_q;
    wb_stage_t wb_q;

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    logic        dec_legal;
    alu_op_e     dec_op;

    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_res;

    assign opcode = id_q.instr[6:0];
    assign rd     = id_q.instr[11:7];
    assign funct3 = id_q.instr[14:12];
    assign rs1    = id_q.instr[19:15];
    assign rs2    = id_q.instr[24:20];
    assign funct7 = id_q.instr[31:25];

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = ALU_ADD;
        if (opcode == OPC_OP) begin
            if (funct7 == F7_BASE) begin
                dec_legal = 1'b1;
                case (funct3)
                    F3_ADD:  dec_op = ALU_ADD;
                    F3_SLL:  dec_op = ALU_SLL;
                    F3_SLT:  dec_op = ALU_SLT;
                    F3_SLTU: dec_op = ALU_SLTU;
                    F3_XOR:  dec_op = ALU_XOR;
                    F3_SR:   dec_op = ALU_SRL;
                    F3_OR:   dec_op = ALU_OR;
                    default: dec_op = ALU_AND;
                endcase
            end else if (funct7 == F7_ALT) begin
                if (funct3 == F3_ADD) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_SUB;
                end else if (funct3 == F3_SR) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_SRA;
                end
            end
        end
    end

    mpu_regfile #(
        .R1_INIT (R1_INIT),
        .R2_INIT (R2_INIT)
    ) u_regfile (
        .clock  (clock),
        .reset  (reset),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .we     (wb_q.we),
        .waddr  (wb_q.rd),
        .wdata  (wb_q.data)
    );

    // Operand read: the younger producer (EX) wins over WB. A stage's we bit
    // is never set for rd == x0, so source x0 falls through to the register
    // file, which returns zero for it.
    always_comb begin
        op_a = rf_rdata1;
        if (ex_q.we && (ex_q.rd == rs1)) begin
            op_a = alu_res;
        end else if (wb_q.we && (wb_q.rd == rs1)) begin
            op_a = wb_q.data;
        end
    end

    always_comb begin
        op_b = rf_rdata2;
        if (ex_q.we && (ex_q.rd == rs2)) begin
            op_b = alu_res;
        end else if (wb_q.we && (wb_q.rd == rs2)) begin
            op_b = wb_q.data;
        end
    end

    always_comb begin
        alu_res = '0;
        case (ex_q.op)
            ALU_ADD:  alu_res = ex_q.a + ex_q.b;
            ALU_SUB:  alu_res = ex_q.a - ex_q.b;
            ALU_SLL:  alu_res = ex_q.a << ex_q.b[4:0];
            ALU_SLT:  alu_res = {31'd0, $signed(ex_q.a) < $signed(ex_q.b)};
            ALU_SLTU: alu_res = {31'd0, ex_q.a < ex_q.b};
            ALU_XOR:  alu_res = ex_q.a ^ ex_q.b;
            ALU_SRL:  alu_res = ex_q.a >> ex_q.b[4:0];
            ALU_SRA:  alu_res = 32'($signed(ex_q.a) >>> ex_q.b[4:0]);
            ALU_OR:   alu_res = ex_q.a | ex_q.b;
            ALU_AND:  alu_res = ex_q.a & ex_q.b;
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_q <= '0;
            ex_q <= '0;
            wb_q <= '0;
        end else begin
            id_q.valid <= 1'b1;
            id_q.instr <= instr;

            ex_q.valid <= id_q.valid;
            ex_q.legal <= dec_legal;
            ex_q.we    <= id_q.valid && dec_legal && (rd != 5'd0);
            ex_q.rd    <= rd;
            ex_q.op    <= dec_op;
            ex_q.a     <= op_a;
            ex_q.b     <= op_b;

            wb_q.valid <= ex_q.valid;
            wb_q.legal <= ex_q.legal;
            wb_q.we    <= ex_q.we;
            wb_q.rd    <= ex_q.rd;
            wb_q.data  <= ex_q.legal ? alu_res : '0;
        end
    end

    assign wb_valid = wb_q.we;
    assign wb_rd    = wb_q.rd;
    assign wb_data  = wb_q.data;
    assign illegal  = wb_q.valid && !wb_q.legal;

endmodule

// File: tb/tb_mpu.sv
// Bench for mpu: an architectural (sequential, one-instruction-at-a-time)
// model of the RV32I R-type subset, whose results are expected at the WB
// outputs two edges after the edge that sampled the instruction.
module tb_mpu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    mpu #(32'd5, 32'd11) dut (
        .clock    (clock),
        .reset    (reset),
        .instr    (instr),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .illegal  (illegal)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] NOP   = 32'h0000_0033; // ADD x0,x0,x0
    localparam logic [31:0] SUB3  = 32'h4020_81B3; // SUB x3,x1,x2
    localparam logic [31:0] ADD3  = 32'h0020_81B3; // ADD x3,x1,x2
    localparam logic [31:0] ADD4  = 32'h0011_8233; // ADD x4,x3,x1
    localparam logic [31:0] CLR3  = 32'h0000_01B3; // ADD x3,x0,x0
    localparam logic [31:0] XOR6  = 32'h0020_C333; // XOR x6,x1,x2
    localparam logic [31:0] ADD0  = 32'h0020_8033; // ADD x0,x1,x2
    localparam logic [31:0] ADD5  = 32'h0010_02B3; // ADD x5,x0,x1
    localparam logic [31:0] ILL1  = 32'h0020_8193; // opcode 0010011
    localparam logic [31:0] ILL2  = 32'h4020_91B3; // funct7 0100000, funct3 001
    localparam logic [31:0] RD3   = 32'h0001_83B3; // ADD x7,x3,x0
    localparam logic [31:0] ADD1  = 32'h0020_80B3; // ADD x1,x1,x2
    localparam logic [31:0] SUB2  = 32'h4011_0133; // SUB x2,x2,x1
    localparam logic [31:0] CPY1  = 32'h0000_8433; // ADD x8,x1,x0
    localparam logic [31:0] CPY2  = 32'h0001_04B3; // ADD x9,x2,x0
    localparam logic [31:0] CPY3  = 32'h0001_8533; // ADD x10,x3,x0

    typedef struct packed {
        bit        present;
        bit        v;
        bit        ill;
        bit [4:0]  rd;
        bit [31:0] data;
    } res_t;

    bit [31:0] arch [32];
    res_t h0, h1, h2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t execute(input bit [31:0] w);
        res_t r;
        bit [31:0] a;
        bit [31:0] b;
        bit [31:0] res;
        bit ok;
        a = arch[w[19:15]];
        b = arch[w[24:20]];
        res = 32'd0;
        ok = 1'b1;
        if (w[6:0] != 7'b0110011) begin
            ok = 1'b0;
        end else begin
            case ({w[31:25], w[14:12]})
                10'b0000000_000: res = a + b;
                10'b0100000_000: res = a - b;
                10'b0000000_001: res = a << b[4:0];
                10'b0000000_010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                10'b0000000_011: res = (a < b) ? 32'd1 : 32'd0;
                10'b0000000_100: res = a ^ b;
                10'b0000000_101: res = a >> b[4:0];
                10'b0100000_101: res = 32'($signed(a) >>> b[4:0]);
                10'b0000000_110: res = a | b;
                10'b0000000_111: res = a & b;
                default:         ok = 1'b0;
            endcase
        end
        r.present = 1'b1;
        r.rd      = w[11:7];
        r.ill     = !ok;
        r.v       = ok && (w[11:7] != 5'd0);
        r.data    = res;
        if (r.v) arch[w[11:7]] = res;
        return r;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) arch[i] = 32'd0;
            arch[1] = 32'd5;
            arch[2] = 32'd11;
            h0 = '0;
            h1 = '0;
            h2 = '0;
        end else begin
            h2 = h1;
            h1 = h0;
            h0 = execute(instr);
        end
    end

    always @(negedge clock) begin
        chk("wb_valid", 32'(wb_valid), 32'(h2.present && h2.v && !reset));
        chk("illegal", 32'(illegal), 32'(h2.present && h2.ill && !reset));
        if (reset) begin
            chk("wb_rd_rst", 32'(wb_rd), 32'd0);
            chk("wb_data_rst", wb_data, 32'd0);
        end else if (h2.present && h2.v) begin
            chk("wb_rd", 32'(wb_rd), 32'(h2.rd));
            chk("wb_data", wb_data, h2.data);
        end
    end

    task automatic step(input logic [31:0] w);
        @(negedge clock);
        instr = w;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step(NOP);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int sel;
        sel = $urandom_range(0, 15);
        w[6:0]   = 7'b0110011;
        w[11:7]  = 5'($urandom_range(0, 7));
        w[14:12] = 3'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        w[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
        if (sel == 0) begin
            w = $urandom();
        end else if (sel == 1) begin
            w[6:0] = 7'b0010011;
        end else if (sel == 2) begin
            w[24:15] = 10'($urandom());
            w[11:7]  = 5'($urandom());
        end
        return w;
    endfunction

    initial begin
        instr = SUB3;
        #50 reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("sub_valid", 32'(wb_valid), 32'd1);
        chk("sub_rd", 32'(wb_rd), 32'd3);
        chk("sub_data", wb_data, 32'hFFFF_FFFA);
        @(negedge clock);
        chk("sub_hold", wb_data, 32'hFFFF_FFFA);

        step(ADD3); settle(3);
        chk("add_rd", 32'(wb_rd), 32'd3);
        chk("add_data", wb_data, 32'd16);

        step(CLR3); settle(3);
        step(ADD3); step(ADD4); settle(3);
        chk("fwd_ex_rd", 32'(wb_rd), 32'd4);
        chk("fwd_ex_data", wb_data, 32'd21);

        step(CLR3); settle(3);
        step(ADD3); step(XOR6); step(ADD4); settle(3);
        chk("fwd_wb_rd", 32'(wb_rd), 32'd4);
        chk("fwd_wb_data", wb_data, 32'd21);

        step(ADD0); settle(3);
        chk("x0_valid", 32'(wb_valid), 32'd0);
        chk("x0_illegal", 32'(illegal), 32'd0);
        step(ADD5); settle(3);
        chk("x0_src_data", wb_data, 32'd5);

        step(ILL1); settle(3);
        chk("ill_opc", 32'(illegal), 32'd1);
        chk("ill_opc_valid", 32'(wb_valid), 32'd0);
        step(NOP);
        chk("ill_one_cycle", 32'(illegal), 32'd0);
        step(ILL2); settle(3);
        chk("ill_f7", 32'(illegal), 32'd1);
        step(RD3); settle(3);
        chk("ill_no_write", wb_data, 32'd16);

        step(ADD3); step(ADD1); step(SUB2);
        #6;
        chk("pre_rst_valid", 32'(wb_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", 32'(wb_valid), 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_rd", 32'(wb_rd), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        @(negedge clock);
        instr = NOP;
        #2 reset = 1'b0;
        step(CPY1); step(CPY2); step(CPY3);
        step(NOP);
        chk("rst_x1", wb_data, 32'd5);
        step(NOP);
        chk("rst_x2", wb_data, 32'd11);
        step(NOP);
        chk("rst_x3", wb_data, 32'd0);
        chk("rst_x3_valid", 32'(wb_valid), 32'd1);

        for (int n = 0; n < 600; n++) begin
            step(rand_instr());
            if (n == 300) begin
                #3 reset = 1'b1;
                #4 reset = 1'b0;
            end
        end
        settle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
